// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and word helpers.
package aes_pkg;

  typedef enum logic [1:0] {StIdle, StFwd, StRev} ks_state_t;

  localparam logic [3:0] LastRound = 4'd10;

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Word 0 is the most significant 32 bits of the key.
  function automatic logic [31:0] get_word(input logic [127:0] k, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = k[127:96];
      2'd1:    w = k[95:64];
      2'd2:    w = k[63:32];
      default: w = k[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inv_key_sched_if.sv
// Key-input / round-key stream handshake bundle for inv_key_sched.
interface inv_key_sched_if;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic         rk_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key, rk_ready,
    input  round_key, round, rk_valid, busy, done
  );

  modport slave (
    input  start, key, rk_ready,
    output round_key, round, rk_valid, busy, done
  );
endinterface

// File: rtl/sbox.sv
// Combinational AES forward S-box.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Entry 0 sits at the top of the packed table, so ~in_byte selects it.
  localparam logic [255:0][7:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SboxTab[~in_byte];
endmodule

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups over a 32-bit word.
module sub_word (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .in_byte  (in_word[8*i +: 8]),
      .out_byte (out_word[8*i +: 8])
    );
  end
endmodule

// File: rtl/inv_key_sched.sv
// AES-128 decryption key sequencer: expands forward to round 10, then streams keys 10..0
// by inverting the recurrence, sharing one SubWord between both directions.
module inv_key_sched
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  inv_key_sched_if.slave bus
);

  ks_state_t    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         rk_valid_q, rk_valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, p3, f0, f1, f2;
  logic [31:0]  sub_in, sub_out, mix;
  logic [7:0]   rc;
  logic         rev, hs;

  assign w0  = get_word(key_q, 2'd0);
  assign w1  = get_word(key_q, 2'd1);
  assign w2  = get_word(key_q, 2'd2);
  assign w3  = get_word(key_q, 2'd3);
  assign p3  = w3 ^ w2;
  assign rev = (state_q == StRev);
  assign hs  = rk_valid_q & bus.rk_ready;

  // Forward uses Rcon of the round being produced, reverse that of the round being undone.
  assign sub_in = rev ? rot_word(p3) : rot_word(w3);
  assign rc     = rev ? rcon(round_q) : rcon(round_q + 4'd1);

  sub_word u_sub_word (
    .in_word  (sub_in),
    .out_word (sub_out)
  );

  assign mix = sub_out ^ {rc, 24'h000000};
  assign f0  = w0 ^ mix;
  assign f1  = w1 ^ f0;
  assign f2  = w2 ^ f1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StFwd;
      StFwd:   if (round_q == LastRound - 4'd1) state_d = StRev;
      StRev:   if (hs && round_q == 4'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.round_key = key_q;
    bus.round     = round_q;
    bus.rk_valid  = rk_valid_q;
    bus.done      = done_q;
  end

  always_comb begin
    key_d      = key_q;
    round_d    = round_q;
    rk_valid_d = rk_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          key_d   = bus.key;
          round_d = 4'd0;
        end
      end
      StFwd: begin
        key_d   = {f0, f1, f2, w3 ^ f2};
        round_d = round_q + 4'd1;
        if (round_q == LastRound - 4'd1) rk_valid_d = 1'b1;
      end
      StRev: begin
        if (hs) begin
          if (round_q != 4'd0) begin
            key_d   = {f0, w1 ^ w0, w2 ^ w1, p3};
            round_d = round_q - 4'd1;
          end else begin
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q      <= '0;
      round_q    <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      key_q      <= key_d;
      round_q    <= round_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/inv_key_sched.md
# inv_key_sched

Round-key sequencer for the AES-128 decryption path. It accepts the 128-bit cipher key and runs the forward key expansion internally to reach the round-10 key. It then streams the round keys in reverse order (round 10 down to round 0) over a valid/ready handshake, stepping backward through the schedule with the inverse recurrence rather than storing all eleven keys. It sits between the key input and the inverse-cipher round datapath, mirroring the forward `expand_key` used by encryption.

## Interface
Parameters: none (AES-128 only).
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a new schedule; sampled only in IDLE
- key  in  128  cipher key, byte 0 in bits [127:120]; captured on accepted start
- rk_ready  in  1  consumer accepts `round_key` this cycle
- round_key  out  128  current round key
- round  out  4  round index of `round_key` (10..0)
- rk_valid  out  1  `round_key` and `round` are valid
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after round-0 key is accepted

## Operation
- States: IDLE, FWD, REV.
- **IDLE.** On `start`=1, load `key` into the key register, set `round`=0, and go to FWD. All other inputs are ignored in IDLE.
- **FWD.** On each edge, replace the key with the next forward key, with round r+1 derived from round r:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[r+1],24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - Increment `round`. On the edge that produces round 10, go to REV and set `rk_valid`=1.
- **REV.** `round_key` and `round` hold steady while `rk_valid` && !`rk_ready`.
  - On a handshake (`rk_valid` && `rk_ready`) with `round`>0, step back from round r to round r-1:
    - p3 = k3 ^ k2
    - p2 = k2 ^ k1
    - p1 = k1 ^ k0
    - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - Decrement `round` and keep `rk_valid`=1, so back-to-back transfers run at one key per cycle.
  - On a handshake with `round`=0: clear `rk_valid`, pulse `done` for the next cycle, and go to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The SubWord input is muxed between w3 (FWD) and p3 (REV). A single SubWord (4 S-box lookups) is shared by both directions.
- `start` during FWD or REV is ignored. Changes to `key` after capture have no effect.
- `round_key` is also driven (not valid) during FWD, showing intermediate keys. Consumers must qualify on `rk_valid`.
- Reset (async, any state): state=IDLE, `round_key`=0, `round`=0, `rk_valid`=0, `busy`=0, `done`=0.

## Timing
- If `start` is accepted at edge N:
  - `busy`=1 after edge N.
  - `rk_valid`=1 with `round`=10 after edge N+10.
- Forward phase takes 10 cycles. Reverse phase takes at least 11 cycles, plus one cycle per stall.
- Minimum start-to-`done` time is 21 cycles. `done` is high during the cycle following the final handshake, with `busy`=0 in that same cycle.
- A new `start` is accepted in the cycle where `done`=1.
- The reset de-assertion edge performs no state update.
- The S-box is combinational, so each step has single-cycle latency. The critical path is S-box → XOR chain → key register.

## Structure
- Shared package `aes_pkg` holds:
  - the state enum `ks_state_t`
  - the `RCON` table (array or function indexed 1..10)
  - `rot_word` and the word-slicing helpers
- Sub-module `sub_word`: four instances of the existing combinational `sbox`, mapping 32→32 bits.
- `inv_key_sched` instantiates exactly one `sub_word`, plus the state register, key register and round counter.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-FWD → all outputs 0 immediately; after release, `busy`=0 and `start` is accepted normally.
- **Round-10 key (FIPS-197 A.1).** `key`=2b7e1516_28aed2a6_abf71588_09cf4f3c, start → after 10 edges `rk_valid`=1, `round`=10, `round_key`=d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- **Full reverse stream.** Same key with `rk_ready`=1 → consecutive cycles deliver:
  - round 9: ac7766f3_19fadc21_28d12941_575c006e
  - round 1: a0fafe17_88542cb1_23a33939_2a6c7605
  - round 0: the cipher key
  - then `done` pulses once.
- **Back-pressure.** Hold `rk_ready`=0 for 5 cycles at round 7 → `round_key`/`round` stable for those cycles; the stream resumes with round 6 and total latency grows by 5.
- **Start while busy.** Pulse `start` with a different `key` during FWD and again during REV → ignored; the output stream matches the original key exactly.
- **Back-to-back runs.** Assert `start` during the `done` cycle with `key`=000102…0f → second run yields round-10 key 13111d7f_e3944a17_f307a78b_4d2b30c5.
